// File: rtl/uop_buffer_pkg.sv
// Shared definitions for the microcode fetch path: buffer depth and the
// instruction bundle layout seen by both the loader and the microcode unit.
package uop_buffer_pkg;

    localparam int UOP_BUF_SIZE = 16;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  dst;
        logic [15:0] imm;
    } instruction_bundle;

endpackage

// File: rtl/uop_ring_ptr.sv
// Wrapping ring index: clears to zero on reset or clr_i, otherwise advances on inc_i.
module uop_ring_ptr #(
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [AW-1:0] ptr_o
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/uop_buffer.sv
// Circular bundle store serving the microcode unit's fetch port; loader writes
// at the tail, consumer releases from the head, flush empties it.
module uop_buffer
    import uop_buffer_pkg::*;
#(
    parameter int  UOP_BUF_SIZE = uop_buffer_pkg::UOP_BUF_SIZE,
    localparam int AW           = $clog2(UOP_BUF_SIZE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  instruction_bundle wr_bundle,
    input  logic [AW-1:0]     uop_addr,
    output instruction_bundle uop,
    output logic              uop_valid,
    input  logic              release_i,
    input  logic              flush,
    output logic [AW-1:0]     head_addr,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);

    instruction_bundle         mem_q [UOP_BUF_SIZE];
    logic [UOP_BUF_SIZE-1:0]   valid_q;
    logic [UOP_BUF_SIZE-1:0]   valid_d;
    logic [AW:0]               count_q;
    logic [AW:0]               count_d;
    logic [AW-1:0]             head_q;
    logic [AW-1:0]             tail_q;
    logic                      wr_fire;
    logic                      rel_fire;

    assign full     = (count_q == (AW+1)'(UOP_BUF_SIZE));
    assign empty    = (count_q == '0);
    assign wr_ready = reset && !full && !flush;
    assign wr_fire  = wr_valid && wr_ready;
    assign rel_fire = release_i && !empty && !flush;

    uop_ring_ptr #(.AW(AW)) u_head (
        .clk_i  (clk),
        .rst_ni (reset),
        .inc_i  (rel_fire),
        .clr_i  (flush),
        .ptr_o  (head_q)
    );

    uop_ring_ptr #(.AW(AW)) u_tail (
        .clk_i  (clk),
        .rst_ni (reset),
        .inc_i  (wr_fire),
        .clr_i  (flush),
        .ptr_o  (tail_q)
    );

    // A write and a release can never hit the same slot: that needs head==tail,
    // where the buffer is either empty (no release) or full (no write).
    always_comb begin
        valid_d = valid_q;
        count_d = count_q;
        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end else begin
            if (wr_fire) valid_d[tail_q] = 1'b1;
            if (rel_fire) valid_d[head_q] = 1'b0;
            if (wr_fire && !rel_fire) begin
                count_d = count_q + (AW+1)'(1);
            end else if (rel_fire && !wr_fire) begin
                count_d = count_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[tail_q] <= wr_bundle;
        end
    end

    assign uop_valid = valid_q[uop_addr];
    assign uop       = valid_q[uop_addr] ? mem_q[uop_addr] : '0;
    assign head_addr = head_q;
    assign count     = count_q;

    // Occupancy must match the valid bits, which must form the ring segment [head, tail).
    logic [UOP_BUF_SIZE-1:0] seg_mask;
    logic [AW:0]             valid_pop;

    always_comb begin
        seg_mask  = '0;
        valid_pop = (AW+1)'($countones(valid_q));
        for (int i = 0; i < UOP_BUF_SIZE; i++) begin
            seg_mask[i] = ({1'b0, AW'(i) - head_q} < count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (count_q == valid_pop);
            assert (valid_q == seg_mask);
        end
    end

endmodule

// File: tb/tb_uop_buffer.sv
// Self-checking bench for uop_buffer at depth 4: vector table plus scoreboarded
// wrap, flush and mid-stream reset sequences.
module tb_uop_buffer;
    import uop_buffer_pkg::*;

    localparam int N  = 4;
    localparam int AW = 2;

    localparam instruction_bundle BZ = 32'h0000_0000;
    localparam instruction_bundle BA = 32'hA101_000A;
    localparam instruction_bundle BB = 32'hB202_000B;
    localparam instruction_bundle BC = 32'hC303_000C;
    localparam instruction_bundle BD = 32'hD404_000D;
    localparam instruction_bundle BE = 32'hE505_000E;
    localparam instruction_bundle BF = 32'hF606_000F;
    localparam instruction_bundle BG = 32'h1707_0010;
    localparam instruction_bundle BH = 32'h2808_0011;
    localparam instruction_bundle BI = 32'h3909_0012;
    localparam instruction_bundle BJ = 32'h4A0A_0013;
    localparam instruction_bundle BK = 32'h5B0B_0014;
    localparam instruction_bundle BL = 32'h6C0C_0015;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_valid;
    logic              wr_ready;
    instruction_bundle wr_bundle;
    logic [AW-1:0]     uop_addr;
    instruction_bundle uop;
    logic              uop_valid;
    logic              release_i;
    logic              flush;
    logic [AW-1:0]     head_addr;
    logic [AW:0]       count;
    logic              full;
    logic              empty;

    always #5 clk = ~clk;

    uop_buffer #(.UOP_BUF_SIZE(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_bundle (wr_bundle),
        .uop_addr  (uop_addr),
        .uop       (uop),
        .uop_valid (uop_valid),
        .release_i (release_i),
        .flush     (flush),
        .head_addr (head_addr),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    typedef struct {
        logic              wv;
        instruction_bundle wb;
        logic [AW-1:0]     addr;
        logic              rel;
        logic              fl;
        logic              rdy;
        logic [AW:0]       cnt;
        logic [AW-1:0]     hd;
        logic              fu;
        logic              em;
        logic              uv;
        instruction_bundle uo;
    } vec_t;

    localparam int NV = 22;
    vec_t              vecs [NV];
    instruction_bundle sb [$];
    int                n_checks = 0;
    int                n_fail   = 0;

    function automatic vec_t row(input logic wv, input instruction_bundle wb, input int a,
                                 input logic rel, input logic fl, input logic rdy, input int cnt,
                                 input int hd, input logic fu, input logic em, input logic uv,
                                 input instruction_bundle uo);
        vec_t v;
        v.wv = wv; v.wb = wb; v.addr = AW'(a); v.rel = rel; v.fl = fl;
        v.rdy = rdy; v.cnt = (AW+1)'(cnt); v.hd = AW'(hd); v.fu = fu; v.em = em;
        v.uv = uv; v.uo = uo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later, before the next rising edge.
    task automatic drive(input logic rst_n, input logic wv, input instruction_bundle wb,
                         input int a, input logic rel, input logic fl);
        @(negedge clk);
        reset = rst_n; wr_valid = wv; wr_bundle = wb; uop_addr = AW'(a);
        release_i = rel; flush = fl;
        #1;
    endtask

    task automatic check_all_empty(input string tag);
        for (int a = 0; a < N; a++) begin
            drive(1'b1, 1'b0, BZ, a, 1'b0, 1'b0);
            chk($sformatf("%s uop_valid[%0d]", tag, a), 64'(uop_valid), 64'(0));
            chk($sformatf("%s uop[%0d]", tag, a), 64'(uop), 64'(0));
        end
        chk({tag, " count"}, 64'(count), 64'(0));
        chk({tag, " head_addr"}, 64'(head_addr), 64'(0));
        chk({tag, " empty"}, 64'(empty), 64'(1));
        chk({tag, " full"}, 64'(full), 64'(0));
        chk({tag, " wr_ready"}, 64'(wr_ready), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_head;
        instruction_bundle wb;

        reset = 1'b0; wr_valid = 1'b0; wr_bundle = BZ; uop_addr = '0;
        release_i = 1'b0; flush = 1'b0;

        vecs[0]  = row(0, BZ, 0, 0, 0,  1, 0, 0, 0, 1, 0, BZ);
        vecs[1]  = row(1, BA, 0, 0, 0,  1, 0, 0, 0, 1, 0, BZ);
        vecs[2]  = row(1, BB, 0, 0, 0,  1, 1, 0, 0, 0, 1, BA);
        vecs[3]  = row(1, BC, 1, 0, 0,  1, 2, 0, 0, 0, 1, BB);
        vecs[4]  = row(1, BD, 2, 0, 0,  1, 3, 0, 0, 0, 1, BC);
        vecs[5]  = row(1, BE, 2, 0, 0,  0, 4, 0, 1, 0, 1, BC);
        vecs[6]  = row(1, BE, 3, 1, 0,  0, 4, 0, 1, 0, 1, BD);
        vecs[7]  = row(1, BE, 0, 0, 0,  1, 3, 1, 0, 0, 0, BZ);
        vecs[8]  = row(0, BZ, 0, 0, 0,  0, 4, 1, 1, 0, 1, BE);
        vecs[9]  = row(0, BZ, 1, 1, 0,  0, 4, 1, 1, 0, 1, BB);
        vecs[10] = row(0, BZ, 1, 1, 0,  1, 3, 2, 0, 0, 0, BZ);
        vecs[11] = row(0, BZ, 3, 1, 0,  1, 2, 3, 0, 0, 1, BD);
        vecs[12] = row(0, BZ, 0, 1, 0,  1, 1, 0, 0, 0, 1, BE);
        vecs[13] = row(0, BZ, 0, 1, 0,  1, 0, 1, 0, 1, 0, BZ);
        vecs[14] = row(1, BF, 1, 0, 0,  1, 0, 1, 0, 1, 0, BZ);
        vecs[15] = row(0, BZ, 1, 0, 0,  1, 1, 1, 0, 0, 1, BF);
        vecs[16] = row(1, BG, 2, 0, 0,  1, 1, 1, 0, 0, 0, BZ);
        vecs[17] = row(1, BH, 1, 0, 0,  1, 2, 1, 0, 0, 1, BF);
        vecs[18] = row(1, BI, 1, 1, 1,  0, 3, 1, 0, 0, 1, BF);
        vecs[19] = row(0, BZ, 0, 0, 0,  1, 0, 0, 0, 1, 0, BZ);
        vecs[20] = row(1, BJ, 0, 0, 0,  1, 0, 0, 0, 1, 0, BZ);
        vecs[21] = row(0, BZ, 0, 0, 0,  1, 1, 0, 0, 0, 1, BJ);

        // Held in reset: loader must be stalled even with traffic presented.
        drive(1'b0, 1'b1, BA, 0, 1'b1, 1'b0);
        chk("in_reset wr_ready", 64'(wr_ready), 64'(0));
        drive(1'b0, 1'b0, BZ, 0, 1'b0, 1'b0);
        chk("in_reset wr_ready idle", 64'(wr_ready), 64'(0));
        check_all_empty("post_reset");

        for (int i = 0; i < NV; i++) begin
            drive(1'b1, vecs[i].wv, vecs[i].wb, int'(vecs[i].addr), vecs[i].rel, vecs[i].fl);
            chk($sformatf("v%0d wr_ready", i), 64'(wr_ready), 64'(vecs[i].rdy));
            chk($sformatf("v%0d count", i), 64'(count), 64'(vecs[i].cnt));
            chk($sformatf("v%0d head_addr", i), 64'(head_addr), 64'(vecs[i].hd));
            chk($sformatf("v%0d full", i), 64'(full), 64'(vecs[i].fu));
            chk($sformatf("v%0d empty", i), 64'(empty), 64'(vecs[i].em));
            chk($sformatf("v%0d uop_valid", i), 64'(uop_valid), 64'(vecs[i].uv));
            chk($sformatf("v%0d uop", i), 64'(uop), 64'(vecs[i].uo));
        end

        // Wrap: 6 writes interleaved with 5 releases, starting from a flushed buffer.
        drive(1'b1, 1'b0, BZ, 0, 1'b0, 1'b1);
        sb.delete();
        exp_head = 0;
        for (int k = 0; k < 11; k++) begin
            if (k % 2 == 0) begin
                wb = instruction_bundle'(32'hC000_0000 + 32'(k));
                drive(1'b1, 1'b1, wb, 0, 1'b0, 1'b0);
                chk($sformatf("wrap%0d wr_ready", k), 64'(wr_ready), 64'(1));
                sb.push_back(wb);
            end else begin
                drive(1'b1, 1'b0, BZ, exp_head, 1'b1, 1'b0);
                chk($sformatf("wrap%0d uop_valid", k), 64'(uop_valid), 64'(1));
                chk($sformatf("wrap%0d uop", k), 64'(uop), 64'(sb.pop_front()));
                exp_head = (exp_head + 1) % N;
            end
        end
        for (int a = 0; a < N; a++) begin
            drive(1'b1, 1'b0, BZ, a, 1'b0, 1'b0);
            chk($sformatf("wrap_end uop_valid[%0d]", a), 64'(uop_valid), 64'(a == 1));
            if (a == 1) chk("wrap_end uop[1]", 64'(uop), 64'(sb[0]));
        end
        chk("wrap_end head_addr", 64'(head_addr), 64'(1));
        chk("wrap_end count", 64'(count), 64'(1));
        drive(1'b1, 1'b1, BL, 2, 1'b0, 1'b0);
        chk("wrap_tail uop_valid before", 64'(uop_valid), 64'(0));
        drive(1'b1, 1'b0, BZ, 2, 1'b0, 1'b0);
        chk("wrap_tail uop_valid", 64'(uop_valid), 64'(1));
        chk("wrap_tail uop", 64'(uop), 64'(BL));

        // Reset dropped mid-stream with count=3 and traffic presented.
        drive(1'b1, 1'b1, BK, 0, 1'b0, 1'b0);
        chk("mid count before reset", 64'(count), 64'(2));
        drive(1'b0, 1'b1, BK, 0, 1'b1, 1'b0);
        chk("mid_reset wr_ready", 64'(wr_ready), 64'(0));
        chk("mid_reset count", 64'(count), 64'(3));
        sb.delete();
        check_all_empty("after_mid_reset");
        drive(1'b1, 1'b1, BK, 0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, BZ, 0, 1'b0, 1'b0);
        chk("after_mid_reset write idx0 valid", 64'(uop_valid), 64'(1));
        chk("after_mid_reset write idx0 uop", 64'(uop), 64'(BK));
        chk("after_mid_reset count", 64'(count), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
